// File: rtl/alu_pipeline.sv
// ---------------------------------------------------------------------------
// alu_pipeline -- two-stage (EX -> WB) ALU pipeline with valid/ready
// handshakes on both the issue side and the writeback side.
//
// This file also holds the alu module that the pipeline instantiates.
//
// alu ports:
//   op   in  4   operation select (encoding listed at the alu module)
//   a    in  64  operand A
//   b    in  64  operand B
//   out  out 64  combinational result
//
// alu_pipeline ports:
//   CLK            in  1   clock, all state updates on posedge
//   nRST           in  1   asynchronous active-low reset
//   issue_valid    in  1   issue side presents an op
//   issue_op       in  4   ALU op
//   issue_A        in  64  operand A
//   issue_B        in  64  operand B
//   issue_dest_PR  in  7   destination physical register tag
//   issue_ready    out 1   op accepted this cycle when issue_valid=1
//   WB_valid       out 1   result presented
//   WB_data        out 64  result value
//   WB_PR          out 7   destination tag of the presented result
//   WB_ready       in  1   consumer accepts the result this cycle
//   ops_completed  out 32  number of retired results (wraps)
// ---------------------------------------------------------------------------

// Op encoding:
//   0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra,
//   8 slt (signed), 9 sltu (unsigned); codes 10..15 produce 0.
// Shift amounts use b[5:0].
module alu (
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic [5:0] shamt;
  assign shamt = b[5:0];

  always_comb begin
    out = '0;
    case (op)
      OP_ADD:  out = a + b;
      OP_SUB:  out = a - b;
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_SLL:  out = a << shamt;
      OP_SRL:  out = a >> shamt;
      OP_SRA:  out = $unsigned($signed(a) >>> shamt);
      OP_SLT:  out = {63'd0, ($signed(a) < $signed(b))};
      OP_SLTU: out = {63'd0, (a < b)};
      default: out = '0;
    endcase
  end

endmodule

module alu_pipeline (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        issue_valid,
  input  logic [3:0]  issue_op,
  input  logic [63:0] issue_A,
  input  logic [63:0] issue_B,
  input  logic [6:0]  issue_dest_PR,
  output logic        issue_ready,
  output logic        WB_valid,
  output logic [63:0] WB_data,
  output logic [6:0]  WB_PR,
  input  logic        WB_ready,
  output logic [31:0] ops_completed
);

  // EX stage
  logic        ex_valid_reg;
  logic [3:0]  ex_op_reg;
  logic [63:0] ex_a_reg;
  logic [63:0] ex_b_reg;
  logic [6:0]  ex_pr_reg;

  // WB stage
  logic        wb_valid_reg;
  logic [63:0] wb_data_reg;
  logic [6:0]  wb_pr_reg;

  logic [31:0] ops_completed_reg;
  logic [31:0] ops_completed_next;

  logic [63:0] alu_out;
  logic        wb_stall;
  logic        ex_stall;
  logic        accept;
  logic        retire;

  alu u_alu (
    .op  (ex_op_reg),
    .a   (ex_a_reg),
    .b   (ex_b_reg),
    .out (alu_out)
  );

  // The EX stage only has to freeze when it holds an op that cannot move
  // into a frozen WB stage. A retiring WB frees a slot in the same cycle,
  // so a full pipeline can still take a new op when WB_ready=1.
  assign wb_stall    = wb_valid_reg & ~WB_ready;
  assign ex_stall    = ex_valid_reg & wb_stall;
  assign issue_ready = ~ex_stall;
  assign accept      = issue_valid & issue_ready;
  assign retire      = wb_valid_reg & WB_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_valid_reg <= 1'b0;
      ex_op_reg    <= '0;
      ex_a_reg     <= '0;
      ex_b_reg     <= '0;
      ex_pr_reg    <= '0;
    end else if (accept) begin
      ex_valid_reg <= 1'b1;
      ex_op_reg    <= issue_op;
      ex_a_reg     <= issue_A;
      ex_b_reg     <= issue_B;
      ex_pr_reg    <= issue_dest_PR;
    end else if (!ex_stall) begin
      // Operand fields are left as they are; only the valid bit drops.
      ex_valid_reg <= 1'b0;
    end
  end

  // Data and tag are only captured from a valid EX stage, so the
  // presented result never changes while the pipeline is idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid_reg <= 1'b0;
      wb_data_reg  <= '0;
      wb_pr_reg    <= '0;
    end else if (!wb_stall) begin
      wb_valid_reg <= ex_valid_reg;
      if (ex_valid_reg) begin
        wb_data_reg <= alu_out;
        wb_pr_reg   <= ex_pr_reg;
      end
    end
  end

  // Natural 32-bit wrap from 0xFFFFFFFF to 0.
  assign ops_completed_next = ops_completed_reg + 32'd1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ops_completed_reg <= '0;
    end else if (retire) begin
      ops_completed_reg <= ops_completed_next;
    end
  end

  assign WB_valid      = wb_valid_reg;
  assign WB_data       = wb_data_reg;
  assign WB_PR         = wb_pr_reg;
  assign ops_completed = ops_completed_reg;

endmodule

// File: tb/tb_alu_pipeline.sv
// ---------------------------------------------------------------------------
// tb_alu_pipeline -- self-checking bench for alu_pipeline.
// Inputs are driven on the falling edge and outputs sampled 1 time unit
// later. The reference model tracks in-flight ops as a FIFO of
// (result, tag, accept step) and derives the expected handshake signals
// from pipeline occupancy and age.
// ---------------------------------------------------------------------------
module tb_alu_pipeline;

  localparam logic [3:0] OP_ADD = 4'd0;

  logic        CLK;
  logic        nRST;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic [63:0] issue_A;
  logic [63:0] issue_B;
  logic [6:0]  issue_dest_PR;
  logic        issue_ready;
  logic        WB_valid;
  logic [63:0] WB_data;
  logic [6:0]  WB_PR;
  logic        WB_ready;
  logic [31:0] ops_completed;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] q_data[$];
  logic [6:0]  q_pr[$];
  int          q_step[$];
  int          step_idx = 0;
  logic [31:0] model_cnt = '0;

  // Per-step expectations produced by the model
  logic        exp_ready;
  logic        exp_valid;
  logic [63:0] exp_data;
  logic [6:0]  exp_pr;
  logic [31:0] exp_cnt;
  logic        acc_obs;

  alu_pipeline dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .issue_valid   (issue_valid),
    .issue_op      (issue_op),
    .issue_A       (issue_A),
    .issue_B       (issue_B),
    .issue_dest_PR (issue_dest_PR),
    .issue_ready   (issue_ready),
    .WB_valid      (WB_valid),
    .WB_data       (WB_data),
    .WB_PR         (WB_PR),
    .WB_ready      (WB_ready),
    .ops_completed (ops_completed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    int sh;
    sh = int'(b % 64);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return $unsigned($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9: return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    q_data.delete();
    q_pr.delete();
    q_step.delete();
    model_cnt = '0;
  endtask

  // One clock cycle: drive inputs, sample DUT, advance the model.
  // An op accepted during step k is presented from step k+2 onward and is
  // the oldest in-flight op whenever it is presented. Two ops in flight
  // means WB is occupied, so only then can WB_ready=0 block issue.
  task automatic step(input logic v, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [6:0] pr, input logic wbr);
    @(negedge CLK);
    issue_valid   = v;
    issue_op      = op;
    issue_A       = a;
    issue_B       = b;
    issue_dest_PR = pr;
    WB_ready      = wbr;
    #1;
    exp_ready = !(q_data.size() == 2 && !wbr);
    exp_valid = (q_data.size() > 0) && (q_step[0] + 2 <= step_idx);
    exp_data  = exp_valid ? q_data[0] : 64'd0;
    exp_pr    = exp_valid ? q_pr[0] : 7'd0;
    exp_cnt   = model_cnt;
    acc_obs   = issue_valid && issue_ready;
    if (exp_valid && wbr) begin
      void'(q_data.pop_front());
      void'(q_pr.pop_front());
      void'(q_step.pop_front());
      model_cnt = model_cnt + 32'd1;
    end
    if (v && exp_ready) begin
      q_data.push_back(model_alu(op, a, b));
      q_pr.push_back(pr);
      q_step.push_back(step_idx);
    end
    step_idx++;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    issue_valid = 1'b1;
    issue_op = OP_ADD;
    issue_A = 64'h1234;
    issue_B = 64'h5678;
    issue_dest_PR = 7'd9;
    WB_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (WB_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0b expected 0", WB_valid); end
    checks++; if (WB_data !== 64'd0) begin errors++; $display("FAIL reset_wb_data: got %0h expected 0", WB_data); end
    checks++; if (WB_PR !== 7'd0) begin errors++; $display("FAIL reset_wb_pr: got %0d expected 0", WB_PR); end
    checks++; if (ops_completed !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ops_completed); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %0b expected 1", issue_ready); end
    // Release just after a rising edge so the very next edge is the first
    // one after deassertion.
    nRST = 1'b1;
    issue_valid = 1'b0;
    $display("reset: WB_valid=%0b WB_data=%0h ops_completed=%0d issue_ready=%0b",
             WB_valid, WB_data, ops_completed, issue_ready);
  endtask

  task automatic test_single();
    step(1'b1, OP_ADD, 64'd5, 64'd7, 7'd3, 1'b1);
    checks++; if (acc_obs !== 1'b1) begin errors++; $display("FAIL single_first_accept: got %0b expected 1", acc_obs); end
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (WB_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", WB_valid); end
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (WB_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", WB_valid); end
    checks++; if (WB_data !== 64'd12) begin errors++; $display("FAIL single_data: got %0d expected 12", WB_data); end
    checks++; if (WB_PR !== 7'd3) begin errors++; $display("FAIL single_pr: got %0d expected 3", WB_PR); end
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (ops_completed !== 32'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", ops_completed); end
    checks++; if (WB_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid: got %0b expected 0", WB_valid); end
    $display("single: add 5+7 -> WB_data=%0d WB_PR=%0d ops_completed=%0d", 12, 3, ops_completed);
  endtask

  task automatic test_back_to_back();
    int n_valid;
    int first_valid;
    int last_valid;
    logic [31:0] start_cnt;
    n_valid = 0;
    first_valid = -1;
    last_valid = -1;
    start_cnt = model_cnt;
    for (int i = 0; i < 9; i++) begin
      if (i < 4) step(1'b1, 4'($urandom_range(0, 9)), rand64(), rand64(), 7'($urandom), 1'b1);
      else       step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
      checks++; if (issue_ready !== exp_ready) begin errors++; $display("FAIL b2b_issue_ready step %0d: got %0b expected %0b", i, issue_ready, exp_ready); end
      checks++; if (WB_valid !== exp_valid) begin errors++; $display("FAIL b2b_wb_valid step %0d: got %0b expected %0b", i, WB_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (WB_data !== exp_data) begin errors++; $display("FAIL b2b_wb_data step %0d: got %0h expected %0h", i, WB_data, exp_data); end
        checks++; if (WB_PR !== exp_pr) begin errors++; $display("FAIL b2b_wb_pr step %0d: got %0d expected %0d", i, WB_PR, exp_pr); end
      end
      if (WB_valid === 1'b1) begin
        n_valid++;
        if (first_valid < 0) first_valid = i;
        last_valid = i;
      end
    end
    checks++; if (n_valid != 4 || first_valid != 2 || last_valid != 5) begin
      errors++; $display("FAIL b2b_valid_run: got %0d cycles at %0d..%0d expected 4 cycles at 2..5", n_valid, first_valid, last_valid);
    end
    checks++; if (ops_completed !== start_cnt + 32'd4) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", ops_completed, start_cnt + 32'd4); end
    $display("back_to_back: %0d results in consecutive cycles, ops_completed=%0d", n_valid, ops_completed);
  endtask

  task automatic test_backpressure();
    logic [63:0] held_data;
    logic [6:0]  held_pr;
    step(1'b1, 4'd1, 64'd100, 64'd1, 7'd10, 1'b0);
    step(1'b1, 4'd4, 64'hF0F0, 64'h0FF0, 7'd11, 1'b0);
    held_data = 64'd99;
    held_pr = 7'd10;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OP_ADD, 64'd40, 64'd2, 7'd12, 1'b0);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_issue_ready cycle %0d: got %0b expected 0", i, issue_ready); end
      checks++; if (WB_valid !== 1'b1) begin errors++; $display("FAIL bp_wb_valid cycle %0d: got %0b expected 1", i, WB_valid); end
      checks++; if (WB_data !== held_data) begin errors++; $display("FAIL bp_wb_data cycle %0d: got %0h expected %0h", i, WB_data, held_data); end
      checks++; if (WB_PR !== held_pr) begin errors++; $display("FAIL bp_wb_pr cycle %0d: got %0d expected %0d", i, WB_PR, held_pr); end
    end
    // Release: oldest retires and the waiting op is taken in the same cycle.
    step(1'b1, OP_ADD, 64'd40, 64'd2, 7'd12, 1'b1);
    checks++; if (acc_obs !== 1'b1) begin errors++; $display("FAIL bp_release_accept: got %0b expected 1", acc_obs); end
    checks++; if (WB_data !== 64'd99 || WB_PR !== 7'd10) begin errors++; $display("FAIL bp_release_first: got %0h/%0d expected 63/10", WB_data, WB_PR); end
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (WB_valid !== 1'b1 || WB_data !== 64'hFF00 || WB_PR !== 7'd11) begin
      errors++; $display("FAIL bp_second: got %0b/%0h/%0d expected 1/ff00/11", WB_valid, WB_data, WB_PR);
    end
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (WB_valid !== 1'b1 || WB_data !== 64'd42 || WB_PR !== 7'd12) begin
      errors++; $display("FAIL bp_third: got %0b/%0h/%0d expected 1/2a/12", WB_valid, WB_data, WB_PR);
    end
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (WB_valid !== 1'b0 || ops_completed !== exp_cnt) begin
      errors++; $display("FAIL bp_drain: got valid %0b count %0d expected valid 0 count %0d", WB_valid, ops_completed, exp_cnt);
    end
    $display("backpressure: held 5 cycles, released, ops_completed=%0d", ops_completed);
  endtask

  task automatic test_reset_mid_stall();
    step(1'b1, OP_ADD, 64'd1, 64'd2, 7'd20, 1'b0);
    step(1'b1, OP_ADD, 64'd3, 64'd4, 7'd21, 1'b0);
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b0);
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b0);
    checks++; if (WB_valid !== 1'b1 || issue_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_full: got valid %0b ready %0b expected 1 0", WB_valid, issue_ready);
    end
    @(negedge CLK);
    WB_ready = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (WB_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b expected 0", WB_valid); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0b expected 1", issue_ready); end
    checks++; if (ops_completed !== 32'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", ops_completed); end
    model_clear();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
      checks++; if (WB_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale step %0d: got %0b expected 0", i, WB_valid); end
    end
    checks++; if (ops_completed !== 32'd0) begin errors++; $display("FAIL rst_mid_no_retire: got %0d expected 0", ops_completed); end
    $display("reset_mid_stall: in-flight ops discarded, ops_completed=%0d", ops_completed);
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    force dut.ops_completed_reg = 32'hFFFF_FFFF;
    #1;
    release dut.ops_completed_reg;
    model_cnt = 32'hFFFF_FFFF;
    step(1'b1, OP_ADD, 64'd2, 64'd2, 7'd5, 1'b1);
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (ops_completed !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_before: got %0h expected ffffffff", ops_completed); end
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (WB_valid !== 1'b1 || WB_data !== 64'd4) begin errors++; $display("FAIL wrap_result: got %0b/%0d expected 1/4", WB_valid, WB_data); end
    step(1'b0, OP_ADD, 64'd0, 64'd0, 7'd0, 1'b1);
    checks++; if (ops_completed !== 32'd0) begin errors++; $display("FAIL wrap_count: got %0h expected 0", ops_completed); end
    $display("wrap: ops_completed after retire = %0h", ops_completed);
  endtask

  task automatic test_random();
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [6:0]  prev_pr;
    int          retired;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_pr = '0;
    retired = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), rand64(), rand64(), 7'($urandom),
           (i >= 390) || ($urandom_range(0, 2) != 0));
      checks++; if (issue_ready !== exp_ready) begin errors++; $display("FAIL rnd_issue_ready step %0d: got %0b expected %0b", i, issue_ready, exp_ready); end
      checks++; if (WB_valid !== exp_valid) begin errors++; $display("FAIL rnd_wb_valid step %0d: got %0b expected %0b", i, WB_valid, exp_valid); end
      checks++; if (ops_completed !== exp_cnt) begin errors++; $display("FAIL rnd_count step %0d: got %0d expected %0d", i, ops_completed, exp_cnt); end
      if (exp_valid) begin
        checks++; if (WB_data !== exp_data) begin errors++; $display("FAIL rnd_wb_data step %0d: got %0h expected %0h", i, WB_data, exp_data); end
        checks++; if (WB_PR !== exp_pr) begin errors++; $display("FAIL rnd_wb_pr step %0d: got %0d expected %0d", i, WB_PR, exp_pr); end
      end
      if (prev_stall) begin
        checks++; if (WB_valid !== 1'b1 || WB_data !== prev_data || WB_PR !== prev_pr) begin
          errors++; $display("FAIL rnd_stable step %0d: got %0b/%0h/%0d expected 1/%0h/%0d", i, WB_valid, WB_data, WB_PR, prev_data, prev_pr);
        end
      end
      if (WB_valid === 1'b1 && WB_ready === 1'b1) retired++;
      prev_stall = (WB_valid === 1'b1) && (WB_ready === 1'b0);
      prev_data = WB_data;
      prev_pr = WB_PR;
    end
    $display("random: 400 cycles, %0d results retired, ops_completed=%0d", retired, ops_completed);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
